key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
- REQ-001: N_KEYS, default 3: number of independent pushbutton channels, range 1..4.
- REQ-002: DB_CYCLES, default 500000: debounce interval in clock cycles (10 ms at 50 MHz); minimum 2.
- REQ-003: REPEAT_DELAY, default 25000000: cycles held before the first auto-repeat; used only when KEY_REPEAT_EN is defined.
- REQ-004: REPEAT_PERIOD, default 5000000: cycles between later auto-repeats; used only when KEY_REPEAT_EN is defined.
- REQ-005: Clock  input  1  50 MHz system clock; all state changes on the rising edge.
- REQ-006: Resetn  input  1  asynchronous, active-low reset.
- REQ-007: KEY_n  input  N_KEYS  raw, asynchronous pushbutton levels; 0 = pressed.
- REQ-008: pressed  output  N_KEYS  debounced level; 1 = pressed.
- REQ-009: press_pulse  output  N_KEYS  one-cycle strobe on each debounced press, and on each repeat if enabled.
- REQ-010: release_pulse  output  N_KEYS  one-cycle strobe on each debounced release.

Function
- REQ-011: Each KEY_n bit SHALL pass through a two-flop synchronizer before any other logic uses it.
- REQ-012: Each channel SHALL hold one stable-state register and one counter of width clog2(DB_CYCLES).
- REQ-013: When the synchronized level equals the stable state, the counter SHALL clear to 0.
- REQ-014: When the levels differ, the counter SHALL increment each cycle.
- REQ-015: At an edge where the counter equals DB_CYCLES-1 and the levels still differ, the stable state SHALL take the synchronized level and the counter SHALL clear.
- REQ-016: Latency: after a clean input change, pressed SHALL change on exactly the (DB_CYCLES+2)th rising edge following the change.
- REQ-017: Any excursion shorter than DB_CYCLES synchronized cycles SHALL leave pressed unchanged and produce no pulse.
- REQ-018: press_pulse (or release_pulse) SHALL be registered, and SHALL be high for exactly the one cycle beginning at the edge where pressed rises (or falls).
- REQ-019: Channels SHALL be fully independent. Simultaneous transitions on several keys SHALL produce pulses in the same cycle.
- REQ-020: press_pulse and release_pulse of one channel SHALL never be high together.

Reset
- REQ-021: While Resetn=0:
  - synchronizer flops SHALL be 1 (released);
  - stable states SHALL be released;
  - counters and repeat timers SHALL be 0;
  - pressed, press_pulse and release_pulse SHALL be 0;
  - all of the above regardless of Clock.
- REQ-022: A reset asserted mid-count SHALL discard the partial count.
- REQ-023: A key held through reset deassertion SHALL be treated as a new press: pressed rises DB_CYCLES+2 edges after Resetn rises, with one press_pulse.

Configuration
- REQ-024: Macro KEY_REPEAT_EN controls auto-repeat.
- REQ-025: With KEY_REPEAT_EN defined, each channel SHALL have a repeat timer, cleared at the initial press_pulse.
  - While pressed stays 1, an extra press_pulse SHALL fire REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles.
  - A release SHALL clear the timer, and no repeat pulse SHALL fire in the release cycle.
- REQ-026: Without KEY_REPEAT_EN, no repeat timer logic SHALL be synthesized, and exactly one press_pulse SHALL occur per debounced press.

Verification (DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_KEYS=3)
- REQ-027: Reset: Resetn=0 with KEY_n=3'b110 -> all outputs 0. After Resetn rises with the key held -> pressed[0]=1 and a single press_pulse[0] at the 6th edge.
- REQ-028: Clean press: KEY_n[1] 1->0, held 20 cycles, then released -> pressed[1] and press_pulse[1] rise at edge 6 (pulse width 1). After the release -> pressed[1]=0 and release_pulse[1] at edge 6.
- REQ-029: Bounce: KEY_n[2] low for 3 cycles, high 2, low 3, then high -> pressed[2] stays 0 and no pulses occur.
- REQ-030: Simultaneous press: KEY_n[0] and KEY_n[2] fall on the same cycle -> both press_pulse bits are high in the same single cycle.
- REQ-031: Reset mid-count: Resetn pulsed low 3 cycles after a KEY_n[0] fall -> no pulse before reset. After reset, press_pulse[0] arrives 6 edges after Resetn rises.
- REQ-032: Repeat: key held 30 cycles past the initial pulse.
  - With KEY_REPEAT_EN: press_pulse at offsets 0, 10, 13, 16, 19, 22, 25, 28 (8 pulses).
  - Without KEY_REPEAT_EN: press_pulse at offset 0 only.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce
//   Debounces N_KEYS active-low pushbuttons. Each key is brought into the
//   Clock domain through a two-flop synchronizer, then has to hold a new
//   level for DB_CYCLES consecutive cycles before the debounced state
//   follows it. Every debounced press and release produces a one-cycle
//   registered strobe.
//
//   Optional feature: define KEY_REPEAT_EN to add per-key auto-repeat.
//   While a key stays pressed, extra press_pulse strobes fire REPEAT_DELAY
//   cycles after the initial strobe and then every REPEAT_PERIOD cycles.
//   Without the macro no repeat logic is built.
//
// Parameters
//   N_KEYS        number of independent keys (1..4)
//   DB_CYCLES     debounce interval in clock cycles (>= 2)
//   REPEAT_DELAY  cycles from the initial press strobe to the first repeat
//   REPEAT_PERIOD cycles between later repeats
//
// Ports
//   Clock          system clock, everything changes on its rising edge
//   Resetn         asynchronous active-low reset
//   KEY_n          raw asynchronous key levels, 0 = pressed
//   pressed        debounced level, 1 = pressed
//   press_pulse    one-cycle strobe per debounced press (and per repeat)
//   release_pulse  one-cycle strobe per debounced release

module key_debounce #(
  parameter int N_KEYS        = 3,
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [N_KEYS-1:0] KEY_n,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Reject parameter values the counters cannot represent.
  if (N_KEYS < 1 || N_KEYS > 4) begin : g_bad_keys
    $error("key_debounce: N_KEYS must be 1..4");
  end
  if (DB_CYCLES < 2) begin : g_bad_db
    $error("key_debounce: DB_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
    $error("key_debounce: repeat intervals must be at least 1");
  end

`ifdef KEY_REPEAT_EN
  // One timer serves both the initial delay and the later period, so it
  // is sized for whichever is longer.
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE         = RPT_W'(1);
`endif

  logic [N_KEYS-1:0] sync_q1;
  logic [N_KEYS-1:0] sync_q2;

  // Two-flop synchronizer. It resets to 1 (released) so a key held
  // through reset is seen as a fresh press once reset lifts.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= KEY_n;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    // stable keeps the raw polarity (1 = released)
    logic             stable;
    logic [CNT_W-1:0] db_cnt;
    logic             differ;
    logic             settle;
    logic             rpt_fire;
    logic             press_q;
    logic             release_q;

    assign differ = sync_q2[i] ^ stable;
    // settle marks the edge where the new level has lasted DB_CYCLES cycles
    assign settle = differ && (db_cnt == DB_LAST);

    // Debounce counter: any return to the stable level discards the count.
    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        stable <= 1'b1;
        db_cnt <= '0;
      end else if (!differ) begin
        db_cnt <= '0;
      end else if (settle) begin
        stable <= sync_q2[i];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_ONE;
      end
    end

`ifdef KEY_REPEAT_EN
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;

    // A settle edge always wins, so the release cycle never also repeats.
    assign rpt_fire = !settle && !stable &&
                      (rpt_first ? (rpt_cnt == RPT_DELAY_LAST)
                                 : (rpt_cnt == RPT_PERIOD_LAST));

    // Repeat timer: restarted by the initial press, counts while held.
    // rpt_first selects the longer initial delay until the first repeat.
    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end else if (settle) begin
        rpt_cnt   <= '0;
        rpt_first <= !sync_q2[i];
      end else if (!stable) begin
        if (rpt_fire) begin
          rpt_cnt   <= '0;
          rpt_first <= 1'b0;
        end else begin
          rpt_cnt <= rpt_cnt + RPT_ONE;
        end
      end else begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Strobes are registered on the same edge that updates stable, so
    // each one lines up exactly with the change of pressed.
    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= (settle && !sync_q2[i]) || rpt_fire;
        release_q <= settle && sync_q2[i];
      end
    end

    assign pressed[i]       = ~stable;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Directed bench for key_debounce with DB_CYCLES=4, REPEAT_DELAY=10,
//   REPEAT_PERIOD=3, N_KEYS=3. Every strobe the DUT should produce is queued
//   with the cycle it must appear in; a monitor pops an entry for each strobe
//   cycle it sees and compares cycle number, strobe bits and pressed level.
//   Handles both builds (with or without KEY_REPEAT_EN).

module tb_key_debounce;

  localparam int NK = 3;

  logic          Clock;
  logic          Resetn;
  logic [NK-1:0] KEY_n;
  logic [NK-1:0] pressed;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;

  typedef struct {
    int            cyc;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] lvl;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  key_debounce #(
    .N_KEYS(NK),
    .DB_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .KEY_n(KEY_n),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  // 10 ns clock; rising edge n happens at 10n-5 ns.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Rising-edge counter that expected strobe times are measured against.
  always @(posedge Clock) cyc <= cyc + 1;

  // Safety net so a broken DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [NK-1:0] act,
                             input logic [NK-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkCycle(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic expectPulse(input int at, input logic [NK-1:0] press,
                             input logic [NK-1:0] rel, input logic [NK-1:0] lvl);
    exp_t e;
    e.cyc   = at;
    e.press = press;
    e.rel   = rel;
    e.lvl   = lvl;
    sb.push_back(e);
  endtask

  // Advance n rising edges and land 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [NK-1:0] keys, input int hold);
    KEY_n = keys;
    step(hold);
  endtask

  // Monitor: each cycle with any strobe high consumes one scoreboard entry.
  always @(negedge Clock) begin
    exp_t e;
    if ((press_pulse | release_pulse) != '0) begin
      checkOutput("pulse_overlap", press_pulse & release_pulse, '0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse: actual press=%b release=%b required=none (cycle %0d)",
                 press_pulse, release_pulse, cyc);
      end else begin
        e = sb.pop_front();
        checkCycle("pulse_cycle", cyc, e.cyc);
        checkOutput("press_pulse", press_pulse, e.press);
        checkOutput("release_pulse", release_pulse, e.rel);
        checkOutput("pressed_at_pulse", pressed, e.lvl);
      end
    end
  end

  // Directed scenarios; C is always the edge count when the input changes,
  // so a clean change shows up at edge C+6.
  initial begin
    int   c;
    exp_t e;

    Resetn = 1'b0;
    KEY_n  = 3'b110;

    // Reset with key 0 held: all outputs low.
    step(3);
    @(negedge Clock);
    checkOutput("reset_pressed", pressed, 3'b000);
    checkOutput("reset_press_pulse", press_pulse, 3'b000);
    checkOutput("reset_release_pulse", release_pulse, 3'b000);

    // Key held through reset release becomes a new press.
    step(1);
    c = cyc;
    Resetn = 1'b1;
    expectPulse(c + 6, 3'b001, 3'b000, 3'b001);
    step(8);
    c = cyc;
    expectPulse(c + 6, 3'b000, 3'b001, 3'b000);
    applyStimulus(3'b111, 12);

    // Clean press of key 1 held 20 cycles.
    c = cyc;
    expectPulse(c + 6, 3'b010, 3'b000, 3'b010);
`ifdef KEY_REPEAT_EN
    for (int k = 16; k <= 25; k += 3) expectPulse(c + k, 3'b010, 3'b000, 3'b010);
`endif
    expectPulse(c + 26, 3'b000, 3'b010, 3'b000);
    applyStimulus(3'b101, 20);
    applyStimulus(3'b111, 12);

    // Bouncing key 2: no debounced change.
    applyStimulus(3'b011, 3);
    applyStimulus(3'b111, 2);
    applyStimulus(3'b011, 3);
    applyStimulus(3'b111, 10);
    @(negedge Clock);
    checkOutput("bounce_pressed", pressed, 3'b000);
    step(1);

    // Keys 0 and 2 together.
    c = cyc;
    expectPulse(c + 6, 3'b101, 3'b000, 3'b101);
    expectPulse(c + 14, 3'b000, 3'b101, 3'b000);
    applyStimulus(3'b010, 8);
    applyStimulus(3'b111, 12);

    // Reset 3 cycles into a key 0 count discards it.
    applyStimulus(3'b110, 3);
    Resetn = 1'b0;
    #2;
    checkOutput("midcount_reset_pressed", pressed, 3'b000);
    step(2);
    c = cyc;
    Resetn = 1'b1;
    expectPulse(c + 6, 3'b001, 3'b000, 3'b001);
    expectPulse(c + 14, 3'b000, 3'b001, 3'b000);
    step(8);
    applyStimulus(3'b111, 12);

    // Auto-repeat: key 1 released so its settle edge lands where a repeat
    // would otherwise fire.
    c = cyc;
    expectPulse(c + 6, 3'b010, 3'b000, 3'b010);
`ifdef KEY_REPEAT_EN
    for (int k = 10; k <= 28; k += 3) expectPulse(c + 6 + k, 3'b010, 3'b000, 3'b010);
`endif
    expectPulse(c + 37, 3'b000, 3'b010, 3'b000);
    applyStimulus(3'b101, 31);
    applyStimulus(3'b111, 12);

    // Asynchronous reset clears a held press without a clock edge.
    c = cyc;
    expectPulse(c + 6, 3'b100, 3'b000, 3'b100);
    applyStimulus(3'b011, 8);
    Resetn = 1'b0;
    #2;
    checkOutput("async_reset_pressed", pressed, 3'b000);
    checkOutput("async_reset_press_pulse", press_pulse, 3'b000);
    KEY_n = 3'b111;
    step(2);
    Resetn = 1'b1;
    step(10);
    @(negedge Clock);
    checkOutput("final_pressed", pressed, 3'b000);

    // Anything left in the scoreboard is a strobe that never appeared.
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL missing_pulse: actual=none required press=%b release=%b at cycle %0d",
               e.press, e.rel, e.cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
